// File: rtl/bomb_pkg.sv
// bomb_pkg: grid constants, cell indexing and the enums shared by the bomb scheduler.
package bomb_pkg;

    localparam int GRID = 10;

    typedef enum logic [1:0] {
        IDLE,
        CENTER,
        RAY,
        HOLD
    } state_e;

    typedef enum logic [1:0] {
        UP,
        DOWN,
        LEFT,
        RIGHT
    } dir_e;

    // Flat map index of a cell: x*GRID + y. Only meaningful for x, y < GRID.
    function automatic logic [6:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        logic [6:0] r;
        r = {3'b000, x} * 7'(GRID) + {3'b000, y};
        return r;
    endfunction

endpackage

// File: rtl/bomb_req_arb.sv
// bomb_req_arb: two-requester round-robin arbiter. A wins first after reset;
// priority flips every cycle in which both requesters are eligible.
module bomb_req_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic acc_a_i,
    input  logic acc_b_i,
    output logic win_a_o,
    output logic win_b_o
);

    logic prio_b_q;

    assign win_a_o = acc_a_i & (~acc_b_i | ~prio_b_q);
    assign win_b_o = acc_b_i & (~acc_a_i |  prio_b_q);

    // Flip priority after every contested cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b_q <= 1'b0;
        end else if (acc_a_i && acc_b_i) begin
            prio_b_q <= ~prio_b_q;
        end
    end

endmodule

// File: rtl/bomb_scheduler.sv
// bomb_scheduler: bomb placement, fuse timing and blast-map generation on a 10x10 grid.
// Optional feature macro: BOMB_CHAIN_EN (rays stop at and detonate other bombs).
//
// state  | meaning
// IDLE   | waiting for an expired slot
// CENTER | marking the centre cell of the selected bomb
// RAY    | walking up/down/left/right, one cell per cycle
// HOLD   | blast map held until BLAST_TICKS ticks have elapsed
module bomb_scheduler
    import bomb_pkg::*;
#(
    parameter int MAX_BOMBS    = 4,
    parameter int FUSE_TICKS   = 3,
    parameter int BLAST_RADIUS = 2,
    parameter int BLAST_TICKS  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [3:0]  xa,
    input  logic [3:0]  ya,
    input  logic [3:0]  xb,
    input  logic [3:0]  yb,
    output logic        gnt_a,
    output logic        gnt_b,
    input  logic [99:0] arena,
    output logic [99:0] bomb_map,
    output logic [99:0] blast_map,
    output logic        busy
);

    localparam int SW = (MAX_BOMBS > 1) ? $clog2(MAX_BOMBS) : 1;
    localparam int FW = $clog2(FUSE_TICKS + 1);
    localparam int RW = $clog2(BLAST_RADIUS + 1);
    localparam int HW = $clog2(BLAST_TICKS + 1);

    logic [MAX_BOMBS-1:0] act_q;
    logic [MAX_BOMBS-1:0] exp_q;
    logic [FW-1:0]        fuse_q [MAX_BOMBS];
    logic [3:0]           bx_q   [MAX_BOMBS];
    logic [3:0]           by_q   [MAX_BOMBS];
    logic [99:0]          bomb_q;
    logic [99:0]          blast_q;
    logic                 gnt_a_q;
    logic                 gnt_b_q;
    logic                 busy_q;
    state_e               state_q;
    dir_e                 dir_q;
    logic [RW-1:0]        step_q;
    logic [HW-1:0]        hold_q;
    logic [SW-1:0]        cur_q;
    logic [3:0]           cx_q;
    logic [3:0]           cy_q;

    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign bomb_map  = bomb_q;
    assign blast_map = blast_q;
    assign busy      = busy_q;

    logic [6:0]    idx_a;
    logic [6:0]    idx_b;
    logic          ok_a;
    logic          ok_b;
    logic          win_a;
    logic          win_b;
    logic          both_fit;
    logic          take_a;
    logic          take_b;
    logic [1:0]    nfree;
    logic [SW-1:0] free0;
    logic [SW-1:0] free1;
    logic [SW-1:0] slot_a;
    logic [SW-1:0] slot_b;

    // Find the two lowest free slots (count saturates at 2).
    always_comb begin
        nfree = 2'd0;
        free0 = '0;
        free1 = '0;
        for (int i = 0; i < MAX_BOMBS; i++) begin
            if (!act_q[i]) begin
                if (nfree == 2'd0) begin
                    free0 = SW'(i);
                    nfree = 2'd1;
                end else if (nfree == 2'd1) begin
                    free1 = SW'(i);
                    nfree = 2'd2;
                end
            end
        end
    end

    // Placement eligibility; both are taken only when the cells differ and two slots are free.
    always_comb begin
        idx_a    = cell_idx(xa, ya);
        idx_b    = cell_idx(xb, yb);
        ok_a     = req_a && (xa < 4'd10) && (ya < 4'd10) && !bomb_q[idx_a] &&
                   !blast_q[idx_a] && !arena[idx_a] && (nfree != 2'd0);
        ok_b     = req_b && (xb < 4'd10) && (yb < 4'd10) && !bomb_q[idx_b] &&
                   !blast_q[idx_b] && !arena[idx_b] && (nfree != 2'd0);
        both_fit = ok_a && ok_b && (idx_a != idx_b) && (nfree == 2'd2);
        take_a   = both_fit || win_a;
        take_b   = both_fit || win_b;
        slot_a   = free0;
        slot_b   = take_a ? free1 : free0;
    end

    bomb_req_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_a_i (ok_a),
        .acc_b_i (ok_b),
        .win_a_o (win_a),
        .win_b_o (win_b)
    );

    logic          any_exp;
    logic [SW-1:0] exp_sel;

    // Lowest-index expired slot.
    always_comb begin
        any_exp = 1'b0;
        exp_sel = '0;
        for (int i = MAX_BOMBS - 1; i >= 0; i--) begin
            if (exp_q[i]) begin
                any_exp = 1'b1;
                exp_sel = SW'(i);
            end
        end
    end

    logic [7:0]           rx;
    logic [7:0]           ry;
    logic [6:0]           ray_idx;
    logic                 ray_out;
    logic                 ray_mark;
    logic                 ray_end;
    logic [MAX_BOMBS-1:0] chain_hit;

    // Current ray cell; 8-bit arithmetic so an underflow lands far above 9.
    always_comb begin
        rx = {4'd0, cx_q};
        ry = {4'd0, cy_q};
        case (dir_q)
            UP:      rx = {4'd0, cx_q} - 8'(step_q);
            DOWN:    rx = {4'd0, cx_q} + 8'(step_q);
            LEFT:    ry = {4'd0, cy_q} - 8'(step_q);
            RIGHT:   ry = {4'd0, cy_q} + 8'(step_q);
            default: rx = {4'd0, cx_q};
        endcase
        ray_out   = (rx > 8'(GRID - 1)) || (ry > 8'(GRID - 1));
        ray_idx   = cell_idx(rx[3:0], ry[3:0]);
        ray_mark  = !ray_out && !arena[ray_idx];
        chain_hit = '0;
`ifdef BOMB_CHAIN_EN
        for (int i = 0; i < MAX_BOMBS; i++) begin
            chain_hit[i] = ray_mark && act_q[i] && (bx_q[i] == rx[3:0]) && (by_q[i] == ry[3:0]);
        end
`endif
        ray_end = !ray_mark || (|chain_hit) || (step_q == RW'(BLAST_RADIUS));
    end

    // Slots, fuses, maps, grants and the explosion FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q   <= '0;
            exp_q   <= '0;
            bomb_q  <= '0;
            blast_q <= '0;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
            dir_q   <= UP;
            step_q  <= '0;
            hold_q  <= '0;
            cur_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            for (int i = 0; i < MAX_BOMBS; i++) begin
                fuse_q[i] <= '0;
                bx_q[i]   <= '0;
                by_q[i]   <= '0;
            end
        end else begin
            gnt_a_q <= take_a;
            gnt_b_q <= take_b;

            if (tick) begin
                for (int i = 0; i < MAX_BOMBS; i++) begin
                    if (act_q[i] && !exp_q[i]) begin
                        if (fuse_q[i] <= FW'(1)) begin
                            fuse_q[i] <= '0;
                            exp_q[i]  <= 1'b1;
                        end else begin
                            fuse_q[i] <= fuse_q[i] - 1'b1;
                        end
                    end
                end
            end

            // New bombs occupy slots that were free, so they never collide with the tick update.
            if (take_a) begin
                act_q[slot_a]  <= 1'b1;
                exp_q[slot_a]  <= 1'b0;
                fuse_q[slot_a] <= FW'(FUSE_TICKS);
                bx_q[slot_a]   <= xa;
                by_q[slot_a]   <= ya;
                bomb_q[idx_a]  <= 1'b1;
            end
            if (take_b) begin
                act_q[slot_b]  <= 1'b1;
                exp_q[slot_b]  <= 1'b0;
                fuse_q[slot_b] <= FW'(FUSE_TICKS);
                bx_q[slot_b]   <= xb;
                by_q[slot_b]   <= yb;
                bomb_q[idx_b]  <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (any_exp) begin
                        cur_q   <= exp_sel;
                        cx_q    <= bx_q[exp_sel];
                        cy_q    <= by_q[exp_sel];
                        state_q <= CENTER;
                        busy_q  <= 1'b1;
                    end
                end
                CENTER: begin
                    blast_q[cell_idx(cx_q, cy_q)] <= 1'b1;
                    dir_q   <= UP;
                    step_q  <= RW'(1);
                    state_q <= RAY;
                end
                RAY: begin
                    if (ray_mark) begin
                        blast_q[ray_idx] <= 1'b1;
                    end
                    for (int i = 0; i < MAX_BOMBS; i++) begin
                        if (chain_hit[i]) begin
                            exp_q[i] <= 1'b1;
                        end
                    end
                    if (ray_end) begin
                        if (dir_q == RIGHT) begin
                            act_q[cur_q]  <= 1'b0;
                            exp_q[cur_q]  <= 1'b0;
                            fuse_q[cur_q] <= '0;
                            bomb_q[cell_idx(cx_q, cy_q)] <= 1'b0;
                            hold_q  <= HW'(BLAST_TICKS);
                            state_q <= HOLD;
                        end else begin
                            dir_q  <= dir_e'(dir_q + 2'd1);
                            step_q <= RW'(1);
                        end
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (hold_q <= HW'(1)) begin
                            blast_q <= '0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            hold_q <= hold_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bomb_scheduler.sv
// tb_bomb_scheduler: table vectors, directed corner sequences and a randomized
// placement/explosion run checked against a cell-set reference model.
module tb_bomb_scheduler;

    localparam int MAXB = 4;
    localparam int R    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        req_a;
    logic        req_b;
    logic [3:0]  xa;
    logic [3:0]  ya;
    logic [3:0]  xb;
    logic [3:0]  yb;
    logic        gnt_a;
    logic        gnt_b;
    logic [99:0] arena;
    logic [99:0] bomb_map;
    logic [99:0] blast_map;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bomb_scheduler #(
        .MAX_BOMBS    (MAXB),
        .FUSE_TICKS   (3),
        .BLAST_RADIUS (R),
        .BLAST_TICKS  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .req_a     (req_a),
        .req_b     (req_b),
        .xa        (xa),
        .ya        (ya),
        .xb        (xb),
        .yb        (yb),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .arena     (arena),
        .bomb_map  (bomb_map),
        .blast_map (blast_map),
        .busy      (busy)
    );

    typedef struct {
        logic       ra;
        logic [3:0] ax;
        logic [3:0] ay;
        logic       rb;
        logic [3:0] bx;
        logic [3:0] by;
        logic       ga;
        logic       gb;
    } vec_t;

    function automatic vec_t mk(input int ra, input int ax, input int ay,
                                input int rb, input int bx, input int by,
                                input int ga, input int gb);
        vec_t v;
        v.ra = 1'(ra); v.ax = 4'(ax); v.ay = 4'(ay);
        v.rb = 1'(rb); v.bx = 4'(bx); v.by = 4'(by);
        v.ga = 1'(ga); v.gb = 1'(gb);
        return v;
    endfunction

    // Expected blast of a lone bomb: centre plus four rays cut by the grid edge or a wall.
    function automatic logic [99:0] blast_of(input int x, input int y, input logic [99:0] ar);
        logic [99:0] m;
        int dx[4];
        int dy[4];
        int nx;
        int ny;
        dx = '{-1, 1, 0, 0};
        dy = '{0, 0, -1, 1};
        m = '0;
        m[x*10+y] = 1'b1;
        for (int d = 0; d < 4; d++) begin
            for (int s = 1; s <= R; s++) begin
                nx = x + dx[d] * s;
                ny = y + dy[d] * s;
                if (nx < 0 || nx > 9 || ny < 0 || ny > 9) break;
                if (ar[nx*10+ny]) break;
                m[nx*10+ny] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [99:0] bit_at(input int i);
        logic [99:0] m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chkm(input string name, input logic [99:0] act, input logic [99:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_busy(input logic v, input int lim, input string name);
        int n;
        n = 0;
        while (busy !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== v) begin
            failures++;
            $display("FAIL %s busy actual=%b required=%b after %0d cycles", name, busy, v, n);
        end
    endtask

    task automatic idle_in();
        req_a = 1'b0; req_b = 1'b0; tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_in();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
    endtask

    // Request in this cycle; grants are sampled one cycle later.
    task automatic place(input logic ra, input int ax, input int ay,
                         input logic rb, input int bx, input int by,
                         output logic ga, output logic gb);
        req_a = ra; xa = 4'(ax); ya = 4'(ay);
        req_b = rb; xb = 4'(bx); yb = 4'(by);
        @(negedge clk);
        ga = gnt_a;
        gb = gnt_b;
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    // Wait for an explosion, check the complete blast and bomb maps in HOLD, then release with one tick.
    task automatic explode_check(input string name, input logic [99:0] exp_blast, input logic [99:0] exp_bomb);
        wait_busy(1'b1, 20, {name, "_start"});
        repeat (1 + 4 * R + 3) @(negedge clk);
        chkm({name, "_blast"}, blast_map, exp_blast);
        chkm({name, "_bomb"}, bomb_map, exp_bomb);
        chk1({name, "_hold_busy"}, busy, 1'b1);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        wait_busy(1'b0, 10, {name, "_end"});
        chkm({name, "_clear"}, blast_map, '0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[8];
        logic        ga;
        logic        gb;
        logic [99:0] exp_m;
        logic [99:0] occ;
        int          cnt;
        logic        ptr_b;
        int          order[$];
        logic        ra;
        logic        rb;
        int          ax;
        int          ay;
        int          bx;
        int          by;
        int          ia;
        int          ib;
        logic        oka;
        logic        okb;
        logic        ea;
        logic        eb;
        int          ci;

        rst_n = 1'b0;
        idle_in();
        xa = '0; ya = '0; xb = '0; yb = '0;
        arena = '0;
        repeat (2) @(negedge clk);

        // Reset state.
        chkm("rst_bomb", bomb_map, '0);
        chkm("rst_blast", blast_map, '0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_gnt_a", gnt_a, 1'b0);
        chk1("rst_gnt_b", gnt_b, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Arbitration and acceptance table, wall at (7,7).
        tbl[0] = mk(1, 5, 5, 1, 5, 5, 1, 0);
        tbl[1] = mk(1, 6, 6, 1, 6, 6, 0, 1);
        tbl[2] = mk(1, 5, 5, 0, 0, 0, 0, 0);
        tbl[3] = mk(1, 10, 2, 1, 2, 12, 0, 0);
        tbl[4] = mk(1, 7, 7, 0, 0, 0, 0, 0);
        tbl[5] = mk(1, 0, 3, 1, 0, 3, 1, 0);
        tbl[6] = mk(1, 1, 1, 1, 2, 2, 0, 1);
        tbl[7] = mk(1, 3, 3, 0, 0, 0, 0, 0);
        arena = bit_at(77);
        for (int i = 0; i < 8; i++) begin
            req_a = tbl[i].ra; xa = tbl[i].ax; ya = tbl[i].ay;
            req_b = tbl[i].rb; xb = tbl[i].bx; yb = tbl[i].by;
            @(negedge clk);
            chk1($sformatf("tbl%0d_gnt_a", i), gnt_a, tbl[i].ga);
            chk1($sformatf("tbl%0d_gnt_b", i), gnt_b, tbl[i].gb);
        end
        idle_in();
        chkm("tbl_bomb_map", bomb_map, bit_at(55) | bit_at(66) | bit_at(3) | bit_at(22));

        // Single bomb at (3,4) on an empty arena.
        do_reset();
        arena = '0;
        place(1'b1, 3, 4, 1'b0, 0, 0, ga, gb);
        chk1("b34_gnt_a", ga, 1'b1);
        chkm("b34_bomb", bomb_map, bit_at(34));
        pulse_tick();
        pulse_tick();
        repeat (4) @(negedge clk);
        chk1("b34_fuse_not_done", busy, 1'b0);
        pulse_tick();
        exp_m = bit_at(34) | bit_at(14) | bit_at(24) | bit_at(44) | bit_at(54) |
                bit_at(32) | bit_at(33) | bit_at(35) | bit_at(36);
        explode_check("b34", exp_m, '0);

        // Corner bomb with a wall below; placed in a tick cycle so the fuse is not decremented.
        do_reset();
        arena = bit_at(10);
        req_a = 1'b1; xa = 4'd0; ya = 4'd0; tick = 1'b1;
        @(negedge clk);
        idle_in();
        chk1("b00_gnt_a", gnt_a, 1'b1);
        @(negedge clk);
        pulse_tick();
        pulse_tick();
        repeat (4) @(negedge clk);
        chk1("b00_fuse_loaded_full", busy, 1'b0);
        pulse_tick();
        explode_check("b00_wall", bit_at(0) | bit_at(1) | bit_at(2), '0);

        // All slots full, then a retry after the first detonation frees one.
        do_reset();
        arena = '0;
        place(1'b1, 0, 0, 1'b1, 0, 9, ga, gb);
        chk1("full_g1a", ga, 1'b1);
        chk1("full_g1b", gb, 1'b1);
        place(1'b1, 9, 0, 1'b1, 9, 9, ga, gb);
        chk1("full_g2a", ga, 1'b1);
        chk1("full_g2b", gb, 1'b1);
        place(1'b1, 5, 5, 1'b0, 0, 0, ga, gb);
        chk1("full_reject", ga, 1'b0);
        pulse_tick();
        pulse_tick();
        pulse_tick();
        wait_busy(1'b1, 20, "full_det_start");
        repeat (1 + 4 * R + 3) @(negedge clk);
        chkm("full_after_first", bomb_map, bit_at(9) | bit_at(90) | bit_at(99));
        place(1'b1, 5, 5, 1'b0, 0, 0, ga, gb);
        chk1("full_retry", ga, 1'b1);
        chkm("full_retry_map", bomb_map, bit_at(9) | bit_at(90) | bit_at(99) | bit_at(55));

        // Neighbouring bombs at (2,2) and (2,3).
        do_reset();
        arena = '0;
        place(1'b1, 2, 2, 1'b0, 0, 0, ga, gb);
        pulse_tick();
        pulse_tick();
        place(1'b1, 2, 3, 1'b0, 0, 0, ga, gb);
        chk1("pair_gnt", ga, 1'b1);
        pulse_tick();
`ifdef BOMB_CHAIN_EN
        explode_check("pair_first", blast_of(2, 2, '0) & ~bit_at(24), bit_at(23));
        repeat (3) @(negedge clk);
        chk1("pair_chain_busy", busy, 1'b1);
`else
        explode_check("pair_first", blast_of(2, 2, '0), bit_at(23));
        repeat (3) @(negedge clk);
        chk1("pair_no_chain_busy", busy, 1'b0);
        pulse_tick();
        explode_check("pair_second", blast_of(2, 3, '0), '0);
`endif

        // Asynchronous reset in the middle of a ray walk.
        do_reset();
        arena = '0;
        place(1'b1, 4, 4, 1'b0, 0, 0, ga, gb);
        pulse_tick();
        pulse_tick();
        pulse_tick();
        wait_busy(1'b1, 20, "abort_start");
        @(negedge clk);
        chk1("abort_centre_set", blast_map[44], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chkm("abort_blast", blast_map, '0);
        chkm("abort_bomb", bomb_map, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized placement against a cell-set model, then serial explosions.
        for (int r = 0; r < 24; r++) begin
            do_reset();
            for (int i = 0; i < 100; i++) arena[i] = ($urandom_range(0, 5) == 0);
            occ = '0;
            cnt = 0;
            ptr_b = 1'b0;
            order.delete();
            for (int c = 0; c < 6; c++) begin
                ra = ($urandom_range(0, 9) < 7);
                rb = ($urandom_range(0, 9) < 7);
                ax = $urandom_range(0, 11);
                ay = $urandom_range(0, 11);
                if ($urandom_range(0, 3) == 0) begin
                    bx = ax; by = ay;
                end else begin
                    bx = $urandom_range(0, 11);
                    by = $urandom_range(0, 11);
                end
                ia = ax * 10 + ay;
                ib = bx * 10 + by;
                oka = ra && ax < 10 && ay < 10 && cnt < MAXB && !occ[ia] && !arena[ia];
                okb = rb && bx < 10 && by < 10 && cnt < MAXB && !occ[ib] && !arena[ib];
                if (oka && okb) begin
                    if (ia == ib || cnt == MAXB - 1) begin
                        ea = !ptr_b;
                        eb = ptr_b;
                    end else begin
                        ea = 1'b1;
                        eb = 1'b1;
                    end
                    ptr_b = !ptr_b;
                end else begin
                    ea = oka;
                    eb = okb;
                end
                if (ea) begin occ[ia] = 1'b1; cnt++; order.push_back(ia); end
                if (eb) begin occ[ib] = 1'b1; cnt++; order.push_back(ib); end
                place(ra, ax, ay, rb, bx, by, ga, gb);
                chk1("rnd_gnt_a", ga, ea);
                chk1("rnd_gnt_b", gb, eb);
                chkm("rnd_bomb_map", bomb_map, occ);
            end
`ifndef BOMB_CHAIN_EN
            if (order.size() > 0) begin
                pulse_tick();
                pulse_tick();
                pulse_tick();
                while (order.size() > 0) begin
                    ci = order.pop_front();
                    occ[ci] = 1'b0;
                    explode_check("rnd_det", blast_of(ci / 10, ci % 10, arena), occ);
                end
            end
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bomb_scheduler.md
BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

Interface
REQ-001 SHALL have parameter MAX_BOMBS, default 4, number of concurrent bomb slots.
REQ-002 SHALL have parameter FUSE_TICKS, default 3, tick pulses from placement to detonation.
REQ-003 SHALL have parameter BLAST_RADIUS, default 2, cells per ray beyond the centre.
REQ-004 SHALL have parameter BLAST_TICKS, default 1, tick pulses the blast map is held.
REQ-005 SHALL have port clk, input, 1, system clock; single clock domain, all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have ports tick input 1 (one-cycle game-time pulse), req_a/req_b input 1, xa/ya/xb/yb input 4 (row/column), gnt_a/gnt_b output 1.
REQ-008 SHALL have ports arena input 100 (1 = wall), bomb_map output 100, blast_map output 100, busy output 1; the cell index is x*10+y in all maps.

Function
REQ-009 Placement SHALL be accepted only if the coordinates are <10, the target bomb_map and blast_map bits are 0, the arena bit is 0, and a slot is free.
REQ-010 If both requests are acceptable in one cycle, a round-robin pointer SHALL pick the winner; A has priority after reset, and the pointer flips after each contested grant.
REQ-011 If both requests target the same cell, or only one slot is free, only the winner SHALL be accepted; otherwise both SHALL be accepted in the same cycle, each taking the lowest free slot in A-then-B order.
REQ-012 gnt_x SHALL pulse one cycle after acceptance, with the bomb_map bit set in that same cycle; rejected requests get no grant and are not queued.
REQ-013 On tick, each active slot fuse SHALL decrement; a fuse reaching 0 marks the slot expired; a bomb placed in the tick cycle loads FUSE_TICKS undecremented.
REQ-014 FSM states SHALL be IDLE, CENTER, RAY, HOLD.
REQ-015 IDLE SHALL go to CENTER when any slot is expired; the lowest expired index is selected.
REQ-016 CENTER SHALL set the centre blast bit for one cycle, then go to RAY.
REQ-017 RAY SHALL visit up (x-1), down (x+1), left (y-1), right (y+1), steps 1..BLAST_RADIUS, one cell per cycle; a ray SHALL end at out-of-grid (4-bit underflow or >9) or at a wall cell, and the wall cell SHALL not be marked.
REQ-018 After RAY the slot SHALL be freed and its bomb_map bit cleared, then the FSM SHALL enter HOLD.
REQ-019 HOLD SHALL clear blast_map after BLAST_TICKS ticks and return to IDLE; worst-case explosion walk is 1+4*BLAST_RADIUS cycles.
REQ-020 busy SHALL be 1 in every state except IDLE; placement continues while busy.
REQ-021 Expiries occurring while busy SHALL stay pending and be served in later IDLE visits.

Reset
REQ-022 On rst_n low, all slots SHALL be freed, fuses zeroed, bomb_map, blast_map, gnt_a, gnt_b and busy set to 0, FSM set to IDLE, and the round-robin pointer set to A.
REQ-023 Reset mid-explosion SHALL abort immediately with no partial blast retained.

Configuration
REQ-024 With BOMB_CHAIN_EN defined, a ray reaching a cell holding another active bomb SHALL mark that cell, end the ray, and set that slot expired.
REQ-025 Without BOMB_CHAIN_EN, rays SHALL pass over bombs and other bombs' fuses SHALL be unaffected.

Structure
REQ-026 A shared package bomb_pkg SHALL hold GRID=10, the cell-index function, the FSM state enum and the direction enum.
REQ-027 Two-requester round-robin arbitration SHALL be a sub-module named bomb_req_arb.

Verification
REQ-028 req_a at (3,4), empty arena -> gnt_a next cycle and bomb_map[34]=1; after 3 ticks, centre plus 8 ray cells (14,24,44,54,32,33,35,36) set in blast_map.
REQ-029 req_a and req_b both at (5,5) in one cycle -> only gnt_a; repeat at (6,6) -> only gnt_b.
REQ-030 Bomb at (0,0), arena[10]=1 -> blast_map shows only 00, 01 and 02; bit 10 stays 0.
REQ-031 Four bombs placed, fifth request -> no grant; after first detonation, retry -> granted.
REQ-032 Bombs at (2,2) and (2,3), first detonates -> with BOMB_CHAIN_EN, second explodes after HOLD; without it, second waits its own fuse.
REQ-033 rst_n asserted during RAY -> busy=0, blast_map=0 and bomb_map=0 asynchronously.
